// File: rtl/sa_pkg.sv
// Shared state encoding, counter widths and saturating arithmetic for the
// systolic matmul engine.
package sa_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FLUSH,
        S_DRAIN
    } sa_state_e;

    localparam int unsigned STEP_CNT_W = 16;
    localparam int unsigned SAT_W      = 64;

    // a + b clamped to the signed range of a w-bit result (w < SAT_W).
    function automatic logic signed [SAT_W-1:0] sat_add(
        input logic signed [SAT_W-1:0] a,
        input logic signed [SAT_W-1:0] b,
        input int unsigned             w
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        logic signed [SAT_W-1:0] s;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        s  = a + b;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage

// File: rtl/systolic_matmul_engine_if.sv
// Job, operand-stream and result-stream signals of the systolic matmul engine.
interface systolic_matmul_engine_if #(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned K_W     = 8
);
    localparam int unsigned IDX_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                          start;
    logic                          acc_mode;
    logic [K_W-1:0]                k_len;
    logic                          in_valid;
    logic                          in_ready;
    logic [ROWS-1:0][BITS_AB-1:0]  A_vec;
    logic [COLS-1:0][BITS_AB-1:0]  B_vec;
    logic                          out_valid;
    logic                          out_ready;
    logic [COLS-1:0][BITS_C-1:0]   out_row;
    logic [IDX_W-1:0]              out_idx;
    logic                          out_last;
    logic                          busy;
    logic                          sat_flag;

    modport master (
        output start, acc_mode, k_len, in_valid, A_vec, B_vec, out_ready,
        input  in_ready, out_valid, out_row, out_idx, out_last, busy, sat_flag
    );

    modport slave (
        input  start, acc_mode, k_len, in_valid, A_vec, B_vec, out_ready,
        output in_ready, out_valid, out_row, out_idx, out_last, busy, sat_flag
    );

endinterface

// File: rtl/sa_pe.sv
// One MAC cell: registers A rightwards and B downwards, and accumulates a*b
// into a saturating accumulator on every grid step.
module sa_pe
    import sa_pkg::*;
#(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      step_i,
    input  logic                      clr_i,
    input  logic signed [BITS_AB-1:0] a_i,
    input  logic signed [BITS_AB-1:0] b_i,
    output logic signed [BITS_AB-1:0] a_o,
    output logic signed [BITS_AB-1:0] b_o,
    output logic signed [BITS_C-1:0]  acc_o,
    output logic                      sat_o
);
    logic signed [BITS_AB-1:0]   a_q;
    logic signed [BITS_AB-1:0]   b_q;
    logic signed [BITS_C-1:0]    acc_q;
    logic signed [BITS_C-1:0]    acc_d;
    logic signed [2*BITS_AB-1:0] prod;
    logic signed [SAT_W-1:0]     sum_raw;
    logic signed [SAT_W-1:0]     sum_sat;

    assign prod    = (2*BITS_AB)'(a_i) * (2*BITS_AB)'(b_i);
    assign sum_raw = SAT_W'(acc_q) + SAT_W'(prod);
    assign sum_sat = sat_add(SAT_W'(acc_q), SAT_W'(prod), BITS_C);
    assign acc_d   = sum_sat[BITS_C-1:0];
    assign sat_o   = step_i && (sum_sat != sum_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (step_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= acc_d;
        end else if (clr_i) begin
            acc_q <= '0;
        end
    end

    assign a_o   = a_q;
    assign b_o   = b_q;
    assign acc_o = acc_q;

endmodule

// File: rtl/systolic_matmul_engine.sv
// Self-sequencing ROWS x COLS systolic matmul: skews incoming A/B beats, steps
// the MAC grid through LOAD and FLUSH, then drains C one row per handshake.
module systolic_matmul_engine
    import sa_pkg::*;
#(
    parameter int unsigned BITS_AB = 8,
    parameter int unsigned BITS_C  = 16,
    parameter int unsigned ROWS    = 8,
    parameter int unsigned COLS    = 8,
    parameter int unsigned K_W     = 8
) (
    input logic               clk,
    input logic               rst,
    systolic_matmul_engine_if.slave bus
);
    localparam int unsigned IDX_W     = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned FLUSH_LEN = ROWS + COLS - 1;

    sa_state_e               state_q;
    logic [K_W-1:0]          k_rem_q;
    logic [STEP_CNT_W-1:0]   flush_cnt_q;
    logic [IDX_W-1:0]        out_idx_q;
    logic                    in_ready_q;
    logic                    out_valid_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    sat_q;

    logic                    clr;
    logic                    step;
    logic [ROWS*COLS-1:0]    pe_sat;
    logic [COLS-1:0][BITS_C-1:0] out_row_w;

    logic signed [BITS_AB-1:0] a_h   [ROWS][COLS+1];
    logic signed [BITS_AB-1:0] b_v   [ROWS+1][COLS];
    logic signed [BITS_C-1:0]  acc_w [ROWS][COLS];

    assign clr  = (state_q == S_IDLE) && bus.start && !bus.acc_mode;
    assign step = (in_ready_q && bus.in_valid) || (state_q == S_FLUSH);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            k_rem_q     <= '0;
            flush_cnt_q <= '0;
            out_idx_q   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        busy_q      <= 1'b1;
                        k_rem_q     <= bus.k_len;
                        flush_cnt_q <= '0;
                        if (bus.k_len == '0) begin
                            state_q <= S_FLUSH;
                        end else begin
                            state_q    <= S_LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.in_valid) begin
                        k_rem_q <= k_rem_q - 1'b1;
                        if (k_rem_q == K_W'(1)) begin
                            state_q    <= S_FLUSH;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                S_FLUSH: begin
                    flush_cnt_q <= flush_cnt_q + 1'b1;
                    if (flush_cnt_q == STEP_CNT_W'(FLUSH_LEN - 1)) begin
                        state_q     <= S_DRAIN;
                        out_valid_q <= 1'b1;
                        out_last_q  <= (ROWS == 1);
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (out_last_q) begin
                            state_q     <= S_IDLE;
                            out_idx_q   <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            out_idx_q  <= out_idx_q + 1'b1;
                            out_last_q <= (out_idx_q == IDX_W'(ROWS - 2));
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            sat_q <= 1'b0;
        end else if (|pe_sat) begin
            sat_q <= 1'b1;
        end
    end

    // Row r sees its A stream r steps late; zeros are shifted in during FLUSH.
    for (genvar r = 0; r < ROWS; r++) begin : g_skew_a
        logic signed [BITS_AB-1:0] a_in;
        assign a_in = in_ready_q ? $signed(bus.A_vec[r]) : '0;
        if (r == 0) begin : g_direct
            assign a_h[r][0] = a_in;
        end else begin : g_dly
            logic signed [BITS_AB-1:0] sr_q [r];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < r; i++) sr_q[i] <= '0;
                end else if (step) begin
                    sr_q[0] <= a_in;
                    for (int unsigned i = 1; i < r; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign a_h[r][0] = sr_q[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_skew_b
        logic signed [BITS_AB-1:0] b_in;
        assign b_in = in_ready_q ? $signed(bus.B_vec[c]) : '0;
        if (c == 0) begin : g_direct
            assign b_v[0][c] = b_in;
        end else begin : g_dly
            logic signed [BITS_AB-1:0] sr_q [c];
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < c; i++) sr_q[i] <= '0;
                end else if (step) begin
                    sr_q[0] <= b_in;
                    for (int unsigned i = 1; i < c; i++) sr_q[i] <= sr_q[i-1];
                end
            end
            assign b_v[0][c] = sr_q[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            sa_pe #(
                .BITS_AB (BITS_AB),
                .BITS_C  (BITS_C)
            ) u_pe (
                .clk    (clk),
                .rst    (rst),
                .step_i (step),
                .clr_i  (clr),
                .a_i    (a_h[r][c]),
                .b_i    (b_v[r][c]),
                .a_o    (a_h[r][c+1]),
                .b_o    (b_v[r+1][c]),
                .acc_o  (acc_w[r][c]),
                .sat_o  (pe_sat[r*COLS+c])
            );
        end
    end

    always_comb begin
        out_row_w = '0;
        for (int unsigned c = 0; c < COLS; c++) begin
            if (out_valid_q) out_row_w[c] = acc_w[out_idx_q][c];
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_w;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = out_last_q;
    assign bus.busy      = busy_q;
    assign bus.sat_flag  = sat_q;

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Bench for systolic_matmul_engine: a plain-arithmetic C = A*B model with
// per-step saturation, a per-cycle output comparator and directed/random jobs.
module tb_systolic_matmul_engine;
    localparam int unsigned BA   = 8;
    localparam int unsigned BC   = 16;
    localparam int unsigned R    = 4;
    localparam int unsigned C    = 3;
    localparam int unsigned KW   = 8;
    localparam int          KMAX = 16;
    localparam int          SMAX = 32767;
    localparam int          SMIN = -32768;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    systolic_matmul_engine_if #(.BITS_AB(BA), .BITS_C(BC), .ROWS(R), .COLS(C), .K_W(KW)) bus();

    systolic_matmul_engine #(
        .BITS_AB (BA),
        .BITS_C  (BC),
        .ROWS    (R),
        .COLS    (C),
        .K_W     (KW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int mc [R][C];
    bit msat;
    int ja [KMAX][R];
    int jb [KMAX][C];
    int got [R][C];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) mc[r][c] = 0;
        msat = 0;
    endtask

    task automatic model_job(input bit am, input int k);
        longint t;
        if (!am) model_clear();
        for (int kk = 0; kk < k; kk++)
            for (int r = 0; r < R; r++)
                for (int c = 0; c < C; c++) begin
                    t = longint'(mc[r][c]) + longint'(ja[kk][r]) * longint'(jb[kk][c]);
                    if (t > SMAX) begin t = SMAX; msat = 1; end
                    if (t < SMIN) begin t = SMIN; msat = 1; end
                    mc[r][c] = int'(t);
                end
    endtask

    // Per-cycle comparator: row contents, index, last flag and stall stability.
    int exp_idx = 0;
    bit pv = 0;
    bit pr = 0;
    logic [C-1:0][BC-1:0] prow;
    int pidx;
    always @(negedge clk) begin
        if (rst) begin
            exp_idx = 0;
            pv = 0;
        end else begin
            if (bus.out_valid) begin
                for (int c = 0; c < C; c++)
                    chk($sformatf("row%0d_col%0d", exp_idx, c), $signed(bus.out_row[c]), mc[exp_idx][c]);
                chk("out_idx", bus.out_idx, exp_idx);
                chk("out_last", bus.out_last, exp_idx == R - 1);
                if (pv && !pr) begin
                    chk("stall_row_stable", longint'(bus.out_row), longint'(prow));
                    chk("stall_idx_stable", bus.out_idx, pidx);
                end
                if (bus.out_ready) exp_idx = (exp_idx + 1) % R;
            end else begin
                chk("out_last_idle", bus.out_last, 0);
            end
            pv   = bus.out_valid;
            pr   = bus.out_ready;
            prow = bus.out_row;
            pidx = bus.out_idx;
        end
    end

    // Called at posedge+#1 with the engine idle; start goes out immediately.
    task automatic do_job(input bit am, input int k, input bit noisy, input int exp_lat);
        int  t0;
        int  i;
        int  guard;
        int  rows;
        bit  hs;
        bit  last;
        model_job(am, k);
        bus.start    = 1;
        bus.acc_mode = am;
        bus.k_len    = KW'(k);
        t0 = cyc;
        @(posedge clk); #1;
        bus.start    = 0;
        bus.acc_mode = 1'($urandom);
        bus.k_len    = KW'($urandom);
        chk("busy_after_start", bus.busy, 1);
        chk("in_ready_after_start", bus.in_ready, k != 0);
        i = 0;
        guard = 0;
        while (i < k && guard < 1000) begin
            bus.in_valid = noisy ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.in_valid) begin
                for (int r = 0; r < R; r++) bus.A_vec[r] = BA'(ja[i][r]);
                for (int c = 0; c < C; c++) bus.B_vec[c] = BA'(jb[i][c]);
            end else begin
                for (int r = 0; r < R; r++) bus.A_vec[r] = BA'($urandom);
                for (int c = 0; c < C; c++) bus.B_vec[c] = BA'($urandom);
            end
            bus.start = noisy && ($urandom_range(0, 3) == 0);
            hs = bus.in_valid && bus.in_ready;
            @(posedge clk); #1;
            guard++;
            if (hs) i++;
        end
        if (i < k) chk("load_timeout_beats", i, k);
        bus.in_valid = 0;
        guard = 0;
        while (!bus.out_valid && guard < 500) begin
            bus.start = noisy && ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            guard++;
        end
        chk("out_valid_seen", bus.out_valid, 1);
        if (exp_lat >= 0) chk("first_out_valid_latency", cyc - t0, exp_lat);
        rows = 0;
        guard = 0;
        last = 0;
        while (!last && guard < 500) begin
            bus.out_ready = noisy ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.start = noisy && ($urandom_range(0, 3) == 0);
            hs = bus.out_valid && bus.out_ready;
            if (hs) begin
                for (int c = 0; c < C; c++) got[bus.out_idx][c] = $signed(bus.out_row[c]);
                last = bus.out_last;
                rows++;
            end
            @(posedge clk); #1;
            guard++;
        end
        bus.out_ready = 0;
        bus.start = 0;
        chk("drain_rows", rows, R);
        chk("busy_after_drain", bus.busy, 0);
        chk("sat_flag", bus.sat_flag, msat);
    endtask

    task automatic load_identity();
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < R; r++) ja[k][r] = (r == k) ? 1 : 0;
            for (int c = 0; c < C; c++) jb[k][c] = 3 * k + c + 1;
        end
    endtask

    initial begin
        rst = 1;
        bus.start = 0;
        bus.acc_mode = 0;
        bus.k_len = '0;
        bus.in_valid = 0;
        bus.A_vec = '0;
        bus.B_vec = '0;
        bus.out_ready = 0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_sat_flag", bus.sat_flag, 0);
        chk("rst_out_row", longint'(bus.out_row), 0);
        rst = 0;
        @(posedge clk); #1;
        chk("idle_busy", bus.busy, 0);

        // Identity A: drained rows are the B rows.
        load_identity();
        do_job(0, 4, 0, 4 + R + C);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) chk("ident_row", got[r][c], 3 * r + c + 1);
        do_job(1, 4, 0, 4 + R + C);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) chk("ident_accum_row", got[r][c], 2 * (3 * r + c + 1));
        do_job(0, 4, 0, 4 + R + C);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) chk("ident_reclear_row", got[r][c], 3 * r + c + 1);

        // 4 * 127 * 127 = 64516 clamps to the positive limit.
        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < R; r++) ja[k][r] = 127;
            for (int c = 0; c < C; c++) jb[k][c] = 127;
        end
        do_job(0, 4, 0, 4 + R + C);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) chk("sat_value", got[r][c], 32767);
        chk("sat_flag_set", bus.sat_flag, 1);
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < R; r++) ja[k][r] = $urandom_range(0, 3);
            for (int c = 0; c < C; c++) jb[k][c] = $urandom_range(0, 3);
        end
        do_job(0, 3, 0, 3 + R + C);
        chk("sat_flag_cleared", bus.sat_flag, 0);

        // Empty jobs: re-drain held C, then drain zeros.
        do_job(1, 0, 0, R + C);
        do_job(0, 0, 0, R + C);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) chk("k0_zero_row", got[r][c], 0);

        for (int j = 0; j < 12; j++) begin
            int k;
            k = $urandom_range(0, 10);
            for (int kk = 0; kk < k; kk++) begin
                for (int r = 0; r < R; r++) ja[kk][r] = int'($urandom_range(0, 255)) - 128;
                for (int c = 0; c < C; c++) jb[kk][c] = int'($urandom_range(0, 255)) - 128;
            end
            do_job(1'($urandom_range(0, 1)), k, 1, -1);
        end

        // Reset in the middle of LOAD.
        bus.start = 1;
        bus.acc_mode = 0;
        bus.k_len = KW'(4);
        @(posedge clk); #1;
        bus.start = 0;
        for (int b = 0; b < 2; b++) begin
            bus.in_valid = 1;
            bus.A_vec = {R{8'sd5}};
            bus.B_vec = {C{8'sd7}};
            @(posedge clk); #1;
        end
        bus.in_valid = 0;
        rst = 1;
        @(posedge clk); #1;
        chk("midload_rst_busy", bus.busy, 0);
        chk("midload_rst_in_ready", bus.in_ready, 0);
        chk("midload_rst_out_valid", bus.out_valid, 0);
        rst = 0;
        model_clear();
        @(posedge clk); #1;
        for (int r = 0; r < R; r++) ja[0][r] = 2;
        for (int c = 0; c < C; c++) jb[0][c] = 3;
        do_job(1, 1, 0, 1 + R + C);
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++) chk("post_rst_row", got[r][c], 6);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
